// File: rtl/lsu_dbus_if.sv
// lsu_dbus_if: core request/response and data-bus handshake signals of the load/store unit.
// master is the LSU view; slave is the core/bus environment view.
interface lsu_dbus_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [XLEN-1:0]     req_addr;
    logic [XLEN-1:0]     req_wdata;
    logic                resp_valid;
    logic                resp_err;
    logic [XLEN-1:0]     resp_rdata;
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic                rd_ready;
    logic                wr_req;
    logic                wr_ready;
    logic [XLEN/8-1:0]   wr_be;
    logic [XLEN-1:0]     wr_data;
    logic [XLEN-1:0]     rd_data;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rd_ready, wr_ready, rd_data,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output addr, rd_req, wr_req, wr_be, wr_data
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rd_ready, wr_ready, rd_data,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  addr, rd_req, wr_req, wr_be, wr_data
    );
endinterface

// File: rtl/lsu_dbus.sv
// lsu_dbus: load/store unit bridging core requests onto the single-outstanding data bus.
// Define LSU_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES with an error response.
module lsu_dbus #(
    parameter int XLEN           = 32,
    parameter int ADDR_LEN       = 14,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic        clk,
    input logic        rstb,
    lsu_dbus_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_size;
    logic                r_uns;
    logic                r_err;
    logic [ADDR_LEN-1:0] r_addr;
    logic [XLEN/8-1:0]   r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_rdata;
    logic                w_err;
    logic                w_to;
    logic                w_unused;
    logic [XLEN/8-1:0]   w_be;
    logic [XLEN-1:0]     w_wd;
    logic [XLEN-1:0]     w_sh;
    logic [XLEN-1:0]     w_ld;

    assign w_err = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                   (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
    assign w_be  = bus.req_size == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
                   bus.req_size == 2'd1 ? 4'b0011 << bus.req_addr[1:0] : 4'hF;
    assign w_wd  = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                   bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    // Words are always aligned, so their shift is zero and they pass through.
    assign w_sh  = bus.rd_data >> {r_addr[1:0], 3'b000};
    assign w_ld  = r_size == 2'd0 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                   r_size == 2'd1 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
    assign w_unused = ^{bus.req_addr[XLEN-1:ADDR_LEN], TIMEOUT_CYCLES[0]};

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    assign w_to = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        r_cnt <= (rstb || r_state == IDLE) ? '0 : r_cnt + 1'b1;
`else
    assign w_to = 1'b0;
`endif

    assign bus.req_ready  = r_state == IDLE;
    assign bus.rd_req     = r_state == RD;
    assign bus.wr_req     = r_state == WR;
    assign bus.resp_valid = r_state == RESP;
    assign bus.resp_err   = r_err;
    assign bus.resp_rdata = r_rdata;
    assign bus.addr       = r_addr;
    assign bus.wr_be      = r_be;
    assign bus.wr_data    = r_wdata;

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_state <= IDLE;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (r_state == IDLE) begin
            if (bus.req_valid) begin
                r_addr  <= bus.req_addr[ADDR_LEN-1:0];
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_err   <= w_err;
                r_be    <= bus.req_we && !w_err ? w_be : '0;
                r_wdata <= bus.req_we && !w_err ? w_wd : '0;
                r_state <= w_err ? RESP : bus.req_we ? WR : RD;
            end
        end else if (r_state == RESP) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if ((r_state == RD && bus.rd_ready) || (r_state == WR && bus.wr_ready)) begin
            r_rdata <= r_state == RD ? w_ld : '0;
            r_state <= RESP;
        end else if (w_to) begin
            r_err   <= 1'b1;
            r_state <= RESP;
        end
    end
endmodule
